// File: rtl/cadr_clk_pkg.sv
// Shared state type, phase-length table and write-pulse timing for the CADR cycle sequencer.
package cadr_clk_pkg;

    localparam int unsigned CNT_W   = 5;
    localparam int unsigned TICK_NS = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RPHASE = 2'd1,
        WPHASE = 2'd2
    } cyc_state_e;

    // Read-phase lengths indexed by {sspeed1, sspeed0, ilong_n}, replacing the 74S151 tap select.
    localparam int RLEN_TAB [8] = '{32, 32, 28, 20, 25, 17, 23, 15};

    localparam int WLEN_TICKS = 12;
    localparam logic [CNT_W:0] WLEN     = (CNT_W + 1)'(WLEN_TICKS);
    localparam logic [CNT_W:0] WP_START = (CNT_W + 1)'(6);
    localparam logic [CNT_W:0] WP_END   = (CNT_W + 1)'(11);

    function automatic logic [CNT_W:0] rlen_of(input logic [2:0] idx);
        rlen_of = (CNT_W + 1)'(RLEN_TAB[idx]);
    endfunction

    function automatic int rlen_max();
        int m;
        m = 0;
        for (int i = 0; i < 8; i++) begin
            if (RLEN_TAB[i] > m) m = RLEN_TAB[i];
        end
        return m;
    endfunction

endpackage

// File: rtl/cadr_cycle_sequencer_if.sv
// Processor-facing timing bus of the cycle sequencer: speed/control inputs in, phase strobes out.
interface cadr_cycle_sequencer_if;
    import cadr_clk_pkg::*;

    logic [1:0]       sspeed;
    logic             ilong_n;
    logic             hang_n;
    logic             machrun;
    logic             run;
    // step_req is a level held until step_ack (a one-tick pulse); it must drop for a tick before the next step.
    logic             step_req;
    logic             step_ack;
    logic             tpclk;
    logic             tpwp;
    logic             tpr0;
    logic             tprend;
    logic             tpdone;
    logic [CNT_W-1:0] phase_cnt;
    cyc_state_e       state;

    modport master (
        input  sspeed, ilong_n, hang_n, machrun, run, step_req,
        output step_ack, tpclk, tpwp, tpr0, tprend, tpdone, phase_cnt, state
    );

    modport slave (
        output sspeed, ilong_n, hang_n, machrun, run, step_req,
        input  step_ack, tpclk, tpwp, tpr0, tprend, tpdone, phase_cnt, state
    );

endinterface

// File: rtl/cadr_phase_counter.sv
// Saturating tick counter with clear/enable; flags when the next count reaches the last tick of a phase.
module cadr_phase_counter
    import cadr_clk_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W:0]   length,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] next_cnt,
    output logic             next_at_end
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_comb begin
        next_cnt = cnt;
        if (clear) begin
            next_cnt = '0;
        end else if (enable && (cnt != CNT_MAX)) begin
            next_cnt = cnt + 1'b1;
        end
    end

    // next_cnt >= length-1, written without the subtraction so a zero length cannot wrap.
    assign next_at_end = (({1'b0, next_cnt} + 1'b1) >= length);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= next_cnt;
        end
    end

endmodule

// File: rtl/cadr_cycle_sequencer.sv
// Synchronous CADR microcycle sequencer: read phase of selectable length, fixed write phase, run/step/hang control.
module cadr_cycle_sequencer
    import cadr_clk_pkg::*;
(
    input  logic                  clk,
    input  logic                  clock_reset_b,
    cadr_cycle_sequencer_if.master bus
);

    if ((rlen_max() > (1 << CNT_W)) || (WLEN_TICKS > (1 << CNT_W))) begin : g_len_check
        $error("cadr_cycle_sequencer: phase length exceeds counter range");
    end

    cyc_state_e       state_q, state_d;
    logic             stepping_q, step_armed_q;
    logic             tpclk_q, tpwp_q, tpr0_q, tprend_q, tpdone_q, step_ack_q;
    logic             advance, step_start, stepped_done;
    logic [CNT_W:0]   rlen, cnt_len;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cnt_end_d;

    // Length is re-selected every tick, so a speed/ilong change takes effect mid-phase like the old mux.
    assign rlen         = rlen_of({bus.sspeed, bus.ilong_n});
    assign step_start   = !bus.run && bus.step_req && step_armed_q;
    assign stepped_done = (state_q == WPHASE) && tpdone_q && stepping_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.hang_n && (bus.run || step_start)) state_d = RPHASE;
            RPHASE:  if (tprend_q) state_d = WPHASE;
            WPHASE:  if (tpdone_q) state_d = (!stepping_q && bus.run && bus.hang_n) ? RPHASE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign advance = (state_d == state_q) && (state_q != IDLE);
    assign cnt_len = (state_d == WPHASE) ? WLEN : rlen;

    cadr_phase_counter u_counter (
        .clk         (clk),
        .rst_n       (clock_reset_b),
        .clear       (!advance),
        .enable      (advance),
        .length      (cnt_len),
        .cnt         (cnt_q),
        .next_cnt    (cnt_d),
        .next_at_end (cnt_end_d)
    );

    // Outputs are decoded from the next state/count so every strobe comes straight off a flop.
    always_ff @(posedge clk or negedge clock_reset_b) begin
        if (!clock_reset_b) begin
            state_q      <= IDLE;
            stepping_q   <= 1'b0;
            step_armed_q <= 1'b1;
            tpclk_q      <= 1'b0;
            tpwp_q       <= 1'b0;
            tpr0_q       <= 1'b0;
            tprend_q     <= 1'b0;
            tpdone_q     <= 1'b0;
            step_ack_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            tpclk_q    <= (state_d == RPHASE);
            tpr0_q     <= (state_d == RPHASE) && !advance;
            tprend_q   <= (state_d == RPHASE) && cnt_end_d;
            tpwp_q     <= (state_d == WPHASE) && bus.machrun &&
                          ({1'b0, cnt_d} >= WP_START) && ({1'b0, cnt_d} < WP_END);
            tpdone_q   <= (state_d == WPHASE) && cnt_end_d;
            step_ack_q <= stepped_done;

            if ((state_q == IDLE) && (state_d == RPHASE)) begin
                stepping_q <= !bus.run;
            end else if (stepped_done) begin
                stepping_q <= 1'b0;
            end

            if (!bus.step_req) begin
                step_armed_q <= 1'b1;
            end else if ((state_q == IDLE) && (state_d == RPHASE) && !bus.run) begin
                step_armed_q <= 1'b0;
            end
        end
    end

    assign bus.tpclk     = tpclk_q;
    assign bus.tpwp      = tpwp_q;
    assign bus.tpr0      = tpr0_q;
    assign bus.tprend    = tprend_q;
    assign bus.tpdone    = tpdone_q;
    assign bus.step_ack  = step_ack_q;
    assign bus.phase_cnt = cnt_q;
    assign bus.state     = state_q;

endmodule
